pc_gen: RTL and testbench

Parametrised program-counter generator for the IF stage, the next generation of the fixed-width PC register. It keeps a next-PC register and presents one fetch address per beat on a valid/ready handshake. It accepts N priority-ordered redirect channels (branch, jump, trap, ...) and tags every beat with an epoch so downstream stages can drop wrong-path instructions. It also flags the first beat after each redirect, and flags redirect targets that are not aligned.

---
 rtl/pc_gen.sv | 121 ++++++++++++
 tb/tb_pc_gen.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the instruction-fetch stage.
//
// The block keeps a next-PC register and presents one fetch address per beat
// on a valid/ready handshake. Every beat carries an epoch tag so that later
// stages can drop wrong-path instructions.
//
// Each clock edge takes the first of these actions that applies:
//   1. Boot: the first edge after reset emits RESET_PC.
//   2. Redirect: the lowest-index asserted channel replaces any pending beat
//      and bumps the epoch.
//   3. Sequential: when the output slot is free and halt is low, emit npc.
//   4. Idle: nothing is emitted, and an unaccepted beat stays where it is.
//
// Ports:
//   clk         clock; all state changes on its rising edge
//   rst         asynchronous reset, active low
//   redir_valid per-channel redirect pulse; channel 0 has the highest priority
//   redir_addr  channel k target at [k*ADDR_W +: ADDR_W]
//   halt        level; suppresses sequential beats
//   out_ready   the fetch stage accepts the current beat
//   out_valid   pc_o, epoch_o, first_o and misalign_o are valid
//   pc_o        fetch address
//   epoch_o     epoch of this beat
//   first_o     first beat after boot or after a redirect
//   misalign_o  the redirect target had nonzero low offset bits
module pc_gen #(
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC   = '0,
    parameter int                INST_BYTES = 4,
    parameter int                N_REDIR    = 2,
    parameter int                EPOCH_W    = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REDIR-1:0]          redir_valid,
    input  logic [N_REDIR*ADDR_W-1:0]   redir_addr,
    input  logic                        halt,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [ADDR_W-1:0]           pc_o,
    output logic [EPOCH_W-1:0]          epoch_o,
    output logic                        first_o,
    output logic                        misalign_o
);

    // Offset bits inside one instruction. With INST_BYTES == 1 this mask is
    // zero, so no address can be misaligned.
    localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'(INST_BYTES - 1);
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(INST_BYTES);

    function automatic logic [ADDR_W-1:0] align_addr(input logic [ADDR_W-1:0] a);
        return a & ~LOW_MASK;
    endfunction

    function automatic logic is_misaligned(input logic [ADDR_W-1:0] a);
        return (a & LOW_MASK) != '0;
    endfunction

    logic [ADDR_W-1:0] npc;
    logic              boot;
    logic              sel_hit;
    logic [ADDR_W-1:0] sel_addr;
    logic              slot_free;

    // Walk from the highest channel down so the lowest-index request wins.
    // Requests that lose are dropped; they are not queued.
    always_comb begin
        sel_hit  = 1'b0;
        sel_addr = '0;
        for (int k = N_REDIR - 1; k >= 0; k--) begin
            if (redir_valid[k]) begin
                sel_hit  = 1'b1;
                sel_addr = redir_addr[k*ADDR_W +: ADDR_W];
            end
        end
    end

    assign slot_free = !out_valid || out_ready;

    // Output register stage. The PC arithmetic wraps modulo 2^ADDR_W.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            npc        <= RESET_PC;
            pc_o       <= '0;
            out_valid  <= 1'b0;
            epoch_o    <= '0;
            first_o    <= 1'b0;
            misalign_o <= 1'b0;
            boot       <= 1'b1;
        end else if (boot) begin
            // The boot beat works like a redirect to RESET_PC, but it keeps
            // epoch 0 and ignores halt.
            pc_o       <= RESET_PC;
            out_valid  <= 1'b1;
            first_o    <= 1'b1;
            misalign_o <= 1'b0;
            npc        <= RESET_PC + STEP;
            boot       <= 1'b0;
        end else if (sel_hit) begin
            // A redirect overrides backpressure and halt, and it replaces
            // any beat that has not been accepted yet.
            pc_o       <= align_addr(sel_addr);
            out_valid  <= 1'b1;
            first_o    <= 1'b1;
            misalign_o <= is_misaligned(sel_addr);
            epoch_o    <= epoch_o + 1'b1;
            npc        <= align_addr(sel_addr) + STEP;
        end else if (slot_free) begin
            if (!halt) begin
                pc_o       <= npc;
                out_valid  <= 1'b1;
                first_o    <= 1'b0;
                misalign_o <= 1'b0;
                npc        <= npc + STEP;
            end else begin
                out_valid  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed bench for pc_gen.
//
// The main DUT uses ADDR_W=32 and RESET_PC=0x100. A second DUT uses
// ADDR_W=8 and RESET_PC=0xFC to show the PC wrapping to 0x00.
//
// Expected beats go into a scoreboard queue when a step is driven. They are
// popped and compared after the edge that should produce them.
module tb_pc_gen;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [1:0]   redir_valid = '0;
    logic [63:0]  redir_addr = '0;
    logic         halt = 1'b0;
    logic         out_ready = 1'b1;
    logic         out_valid;
    logic [31:0]  pc_o;
    logic [1:0]   epoch_o;
    logic         first_o;
    logic         misalign_o;

    logic [1:0]   redir_valid8 = '0;
    logic [15:0]  redir_addr8 = '0;
    logic         halt8 = 1'b0;
    logic         out_ready8 = 1'b1;
    logic         out_valid8;
    logic [7:0]   pc8;
    logic [1:0]   epoch8;
    logic         first8;
    logic         misalign8;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  ep;
        logic        first;
        logic        mis;
    } beat_t;

    beat_t sb_q[$];

    always #5 clk = ~clk;

    pc_gen #(.ADDR_W(32), .RESET_PC(32'h100), .INST_BYTES(4), .N_REDIR(2), .EPOCH_W(2)) dut (
        .clk(clk), .rst(rst), .redir_valid(redir_valid), .redir_addr(redir_addr),
        .halt(halt), .out_ready(out_ready), .out_valid(out_valid), .pc_o(pc_o),
        .epoch_o(epoch_o), .first_o(first_o), .misalign_o(misalign_o)
    );

    pc_gen #(.ADDR_W(8), .RESET_PC(8'hFC), .INST_BYTES(4), .N_REDIR(2), .EPOCH_W(2)) dut8 (
        .clk(clk), .rst(rst), .redir_valid(redir_valid8), .redir_addr(redir_addr8),
        .halt(halt8), .out_ready(out_ready8), .out_valid(out_valid8), .pc_o(pc8),
        .epoch_o(epoch8), .first_o(first8), .misalign_o(misalign8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_beat(input logic [31:0] pc, input logic [1:0] ep,
                               input logic f, input logic m);
        beat_t b;
        b.pc = pc; b.ep = ep; b.first = f; b.mis = m;
        sb_q.push_back(b);
    endtask

    task automatic check_beat(input string tag);
        beat_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_pc"}, pc_o, e.pc);
            chk({tag, "_epoch"}, 32'(epoch_o), 32'(e.ep));
            chk({tag, "_first"}, 32'(first_o), 32'(e.first));
            chk({tag, "_misalign"}, 32'(misalign_o), 32'(e.mis));
        end
    endtask

    initial begin
        // Reset state.
        #2 rst = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_pc", pc_o, 32'd0);
        chk("rst_epoch", 32'(epoch_o), 32'd0);
        chk("rst_first", 32'(first_o), 32'd0);
        chk("rst_misalign", 32'(misalign_o), 32'd0);
        step();
        step();
        rst = 1'b1;

        // Boot, then sequential beats with out_ready=1.
        expect_beat(32'h100, 2'd0, 1'b1, 1'b0);
        step();
        check_beat("boot");
        chk("wrap8_boot_pc", 32'(pc8), 32'hFC);
        expect_beat(32'h104, 2'd0, 1'b0, 1'b0);
        step();
        check_beat("seq1");
        chk("wrap8_pc", 32'(pc8), 32'h00);
        chk("wrap8_valid", 32'(out_valid8), 32'd1);
        expect_beat(32'h108, 2'd0, 1'b0, 1'b0);
        step();
        check_beat("seq2");

        // Backpressure: the 0x108 beat must stay stable.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_pc", pc_o, 32'h108);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        expect_beat(32'h10C, 2'd0, 1'b0, 1'b0);
        step();
        check_beat("after_stall");

        // Both channels fire; channel 0 wins, and its misaligned target is flagged.
        redir_valid = 2'b11;
        redir_addr  = {32'h3000, 32'h2002};
        expect_beat(32'h2000, 2'd1, 1'b1, 1'b1);
        step();
        redir_valid = 2'b00;
        check_beat("redir_prio");
        expect_beat(32'h2004, 2'd1, 1'b0, 1'b0);
        step();
        check_beat("redir_next");

        // Redirect to 0x40, then stall on that beat.
        redir_valid = 2'b01;
        redir_addr  = {32'h0, 32'h40};
        expect_beat(32'h40, 2'd2, 1'b1, 1'b0);
        step();
        redir_valid = 2'b00;
        check_beat("redir_40");
        out_ready = 1'b0;
        step();
        chk("hold_40_pc", pc_o, 32'h40);

        // A redirect during the stall replaces the 0x40 beat; then the epoch wraps.
        redir_valid = 2'b10;
        redir_addr  = {32'h80, 32'h0};
        expect_beat(32'h80, 2'd3, 1'b1, 1'b0);
        step();
        redir_valid = 2'b00;
        check_beat("redir_over_stall");
        redir_valid = 2'b10;
        redir_addr  = {32'h90, 32'h0};
        expect_beat(32'h90, 2'd0, 1'b1, 1'b0);
        step();
        check_beat("epoch_wrap0");
        redir_valid = 2'b01;
        redir_addr  = {32'h0, 32'hA0};
        expect_beat(32'hA0, 2'd1, 1'b1, 1'b0);
        step();
        check_beat("epoch_wrap1");

        // Halt while the 0x200 beat is pending.
        redir_addr  = {32'h0, 32'h200};
        expect_beat(32'h200, 2'd2, 1'b1, 1'b0);
        step();
        redir_valid = 2'b00;
        check_beat("redir_200");
        halt = 1'b1;
        step();
        chk("halt_hold_pc", pc_o, 32'h200);
        chk("halt_hold_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        step();
        chk("halt_idle_valid", 32'(out_valid), 32'd0);
        step();
        chk("halt_idle2_valid", 32'(out_valid), 32'd0);
        halt = 1'b0;
        expect_beat(32'h204, 2'd2, 1'b0, 1'b0);
        step();
        check_beat("halt_release");

        // Asynchronous reset between edges, with halt high during boot.
        #2 rst = 1'b0;
        #1;
        chk("async_valid", 32'(out_valid), 32'd0);
        chk("async_pc", pc_o, 32'd0);
        chk("async_epoch", 32'(epoch_o), 32'd0);
        chk("async_first", 32'(first_o), 32'd0);
        @(posedge clk);
        #1;
        halt = 1'b1;
        rst = 1'b1;
        expect_beat(32'h100, 2'd0, 1'b1, 1'b0);
        step();
        check_beat("reboot");
        step();
        chk("reboot_halt_valid", 32'(out_valid), 32'd0);
        halt = 1'b0;
        expect_beat(32'h104, 2'd0, 1'b0, 1'b0);
        step();
        check_beat("reboot_seq");

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
